fan_duty_scheduler: RTL
=======================

FAN_DUTY_SCHEDULER -- requirements
Module: fan_duty_scheduler

Interface
REQ-001: Parameter TICK_DIV, default 100000, clock cycles per one-code duty ramp step.
REQ-002: Parameter KICK_CYCLES, default 50000000, spin-up kick duration and stall cool-off duration, in cycles.
REQ-003: Parameter STALL_WINDOW, default 100000000, maximum cycles between tach edges before a stall is declared.
REQ-004: Parameter MAX_RETRY, default 3, kick retries before FAULT.
REQ-005: CLK  input  1  single clock; all logic on rising edge.
REQ-006: RST  input  1  reset, synchronous and active-high.
REQ-007: fan_enable  input  1  fan allowed to run.
REQ-008: fanspeed  input  3  thermal request code, 0..4 valid.
REQ-009: host_override_en  input  1  host duty replaces thermal request.
REQ-010: host_duty  input  4  host duty code, 0..9 valid.
REQ-011: tach_in  input  1  asynchronous fan tachometer pulse.
REQ-012: fanmanu_en  output  1  manual-duty enable to the PWM generator.
REQ-013: fanmanu_duty  output  4  duty code to the PWM generator, 0..9.
REQ-014: fan_gate  output  1  PWM output gate; 0 forces the fan pin low.
REQ-015: fan_stall  output  1  sticky stall fault flag.
REQ-016: fan_state  output  3  current state encoding (OFF=0, KICK=1, RAMP=2, RUN=3, COOL=4, FAULT=5).

Function
REQ-017: Target code SHALL be min(host_duty,9) when host_override_en=1; otherwise the thermal map 0->1, 1->3, 2->5, 3->7, 4->9, with codes 5..7 mapping to 9.
REQ-018: tach_in SHALL pass through a 2-flop synchroniser; a rising edge of the synchronised signal is a tach event, detected 3 cycles after the input edge.
REQ-019: OFF: gate=0, en=0, duty=0; go to KICK on the cycle after fan_enable=1.
REQ-020: KICK: gate=1, en=1, duty=9 for exactly KICK_CYCLES cycles, then RAMP.
REQ-021: RAMP: every TICK_DIV cycles, duty SHALL move one code toward the target; on equality, go to RUN; if entered already equal, go to RUN the next cycle.
REQ-022: RUN: hold duty; a target differing from duty SHALL move the FSM to RAMP the next cycle, with the step timer restarted.
REQ-023: Target changes during RAMP SHALL retarget without restarting the step timer; duty SHALL never step past the target nor leave 0..9.
REQ-024: Stall window counter SHALL run in KICK, RAMP and RUN, clear on every tach event, and clear on entry to KICK.
REQ-025: Reaching STALL_WINDOW without a tach event SHALL increment retry_cnt; if the result is <MAX_RETRY, go to COOL, else go to FAULT.
REQ-026: COOL: gate=0, en=1, duty held, for KICK_CYCLES cycles, then KICK.
REQ-027: FAULT: gate=0, en=0, duty=0, fan_stall=1; remain in FAULT while fan_enable=1.
REQ-028: retry_cnt SHALL clear on any tach event in RUN and on entry to OFF.
REQ-029: fan_enable=0 in any state SHALL force OFF the next cycle; this clears fan_stall and retry_cnt and has priority over all other transitions.
REQ-030: Stall timeout and a tach event in the same cycle SHALL count as a tach event, with no stall.
REQ-031: All outputs SHALL be registered.

Reset
REQ-032: While RST=1: state=OFF, fanmanu_en=0, fanmanu_duty=0, fan_gate=0, fan_stall=0; all counters and synchroniser flops cleared.
REQ-033: RST asserted mid-KICK, RAMP or FAULT SHALL behave identically to power-on reset, with no residual count.

Structure
REQ-034: The state encoding and the thermal-code-to-duty map SHALL live in shared package fan_pkg, for reuse by the PWM and status blocks.
REQ-035: The tach synchroniser plus edge detector SHALL be a sub-module fan_tach_sync; counters and the FSM stay in fan_duty_scheduler.

Verification (TICK_DIV=4, KICK_CYCLES=8, STALL_WINDOW=32, MAX_RETRY=2)
REQ-036: fan_enable 0->1, fanspeed=1, tach every 10 cycles -> KICK with duty 9 for 8 cycles, then duty 8,7,6,5,4,3 at 4-cycle spacing, then RUN with duty 3 and gate=1.
REQ-037: In RUN at duty 3, host_override_en=1 with host_duty=12 -> RAMP up to duty 9; override released -> ramp back down to 3.
REQ-038: No tach after enable -> KICK, COOL (gate=0, 8 cycles), KICK, then FAULT with fan_stall=1, duty=0, en=0; fan_enable=0 -> OFF and fan_stall=0.
REQ-039: Tach pulse arriving in the same cycle as the window expiry -> no retry_cnt increment and no COOL.
REQ-040: RST=1 for one cycle mid-RAMP -> all outputs 0 on the next edge; state OFF; a new KICK starts only after fan_enable is seen.

Source files
------------

// File: rtl/fan_pkg.sv
// Shared fan control types: state encoding and thermal-code to duty map.
// Used by the duty scheduler and by the PWM and status blocks.
package fan_pkg;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_KICK  = 3'd1,
    ST_RAMP  = 3'd2,
    ST_RUN   = 3'd3,
    ST_COOL  = 3'd4,
    ST_FAULT = 3'd5
  } fan_state_e;

  localparam logic [3:0] DUTY_MAX = 4'd9;

  function automatic logic [3:0] thermal_duty(
    input logic [2:0] code
  );
    logic [3:0] d;
    case (code)
      3'd0:    d = 4'd1;
      3'd1:    d = 4'd3;
      3'd2:    d = 4'd5;
      3'd3:    d = 4'd7;
      default: d = DUTY_MAX;
    endcase
    return d;
  endfunction

  function automatic logic [3:0] target_duty(
    input logic       ovr,
    input logic [3:0] host,
    input logic [2:0] code
  );
    logic [3:0] d;
    if (ovr) d = (host > DUTY_MAX) ? DUTY_MAX : host;
    else     d = thermal_duty(code);
    return d;
  endfunction

endpackage

// File: rtl/fan_tach_sync.sv
// Tachometer synchroniser with registered rising-edge pulse.
// The pulse appears three clocks after the raw input edge.
module fan_tach_sync (
  input  logic clk,
  input  logic rst,
  input  logic tach_in,
  output logic tach_ev
);

  logic [2:0] sync_q, sync_d;
  logic       ev_q, ev_d;

  always_comb begin
    sync_d = {sync_q[1:0], tach_in};
    ev_d   = sync_q[1] & ~sync_q[2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      ev_q   <= 1'b0;
    end else begin
      sync_q <= sync_d;
      ev_q   <= ev_d;
    end
  end

  assign tach_ev = ev_q;

endmodule

// File: rtl/fan_duty_scheduler.sv
// Fan duty scheduler: spin-up kick, duty ramping, stall retry and fault.
// All outputs are registered and derived from the next state.
module fan_duty_scheduler
  import fan_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned KICK_CYCLES  = 50000000,
  parameter int unsigned STALL_WINDOW = 100000000,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       fan_enable,
  input  logic [2:0] fanspeed,
  input  logic       host_override_en,
  input  logic [3:0] host_duty,
  input  logic       tach_in,
  output logic       fanmanu_en,
  output logic [3:0] fanmanu_duty,
  output logic       fan_gate,
  output logic       fan_stall,
  output logic [2:0] fan_state
);

  localparam int unsigned PH_MAX =
    (KICK_CYCLES > TICK_DIV) ? KICK_CYCLES : TICK_DIV;
  localparam int CW = $clog2(PH_MAX + 1);
  localparam int WW = $clog2(STALL_WINDOW + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  fan_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] win_q, win_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [RW-1:0] retry_inc;
  logic [3:0]    duty_q, duty_d;
  logic [3:0]    target;
  logic          en_q, en_d;
  logic          gate_q, gate_d;
  logic          stall_q, stall_d;
  logic          tach_ev;
  logic          active;
  logic          stall_hit;

  fan_tach_sync u_tach (
    .clk     (CLK),
    .rst     (RST),
    .tach_in (tach_in),
    .tach_ev (tach_ev)
  );

  assign target    = target_duty(host_override_en, host_duty, fanspeed);
  assign active    = state_q inside {ST_KICK, ST_RAMP, ST_RUN};
  assign retry_inc = retry_q + 1'b1;
  // A tach event in the expiry cycle wins over the timeout.
  assign stall_hit = active && !tach_ev &&
                     (win_q == WW'(STALL_WINDOW - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    duty_d  = duty_q;
    retry_d = retry_q;
    win_d   = '0;
    if (active) win_d = tach_ev ? '0 : win_q + 1'b1;
    if (state_q == ST_RUN && tach_ev) retry_d = '0;

    if (!fan_enable) begin
      state_d = ST_OFF;
      cnt_d   = '0;
      win_d   = '0;
      retry_d = '0;
    end else if (stall_hit) begin
      retry_d = retry_inc;
      cnt_d   = '0;
      win_d   = '0;
      state_d = (retry_inc < RW'(MAX_RETRY)) ? ST_COOL : ST_FAULT;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          state_d = ST_KICK;
          cnt_d   = '0;
        end
        ST_KICK: begin
          if (cnt_q == CW'(KICK_CYCLES - 1)) begin
            state_d = ST_RAMP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RAMP: begin
          if (duty_q == target) begin
            state_d = ST_RUN;
          end else if (cnt_q == CW'(TICK_DIV - 1)) begin
            cnt_d  = '0;
            duty_d = (duty_q < target) ? duty_q + 4'd1
                                       : duty_q - 4'd1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (duty_q != target) begin
            state_d = ST_RAMP;
            cnt_d   = '0;
          end
        end
        ST_COOL: begin
          if (cnt_q == CW'(KICK_CYCLES - 1)) begin
            state_d = ST_KICK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_FAULT: ;
        default: state_d = ST_OFF;
      endcase
    end

    gate_d  = state_d inside {ST_KICK, ST_RAMP, ST_RUN};
    en_d    = gate_d || (state_d == ST_COOL);
    stall_d = (state_d == ST_FAULT);
    if (state_d == ST_KICK)
      duty_d = DUTY_MAX;
    else if (state_d inside {ST_OFF, ST_FAULT})
      duty_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      win_q   <= '0;
      retry_q <= '0;
      duty_q  <= '0;
      en_q    <= 1'b0;
      gate_q  <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      retry_q <= retry_d;
      duty_q  <= duty_d;
      en_q    <= en_d;
      gate_q  <= gate_d;
      stall_q <= stall_d;
    end
  end

  assign fanmanu_en   = en_q;
  assign fanmanu_duty = duty_q;
  assign fan_gate     = gate_q;
  assign fan_stall    = stall_q;
  assign fan_state    = state_q;

endmodule
